// File: rtl/spectral_peak_picker.sv
// Spectral peak picker: finds per-bin local maxima over frequency and time
// in a stream of FFT magnitude frames.
module spectral_peak_picker #(
    parameter int NFREQS  = 256,
    parameter int NPEAKS  = 6,
    parameter int AMPL_W  = 32,
    parameter int FINAL_W = 8,
    parameter int FREQ_W  = $clog2(NFREQS),
    parameter int TIME_W  = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [AMPL_W-1:0]    in_data,
    input  logic                        in_last,
    input  logic [NPEAKS*FREQ_W-1:0]    bin_edges,
    input  logic signed [AMPL_W-1:0]    threshold,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NPEAKS*FINAL_W-1:0]   amplitudes_out,
    output logic [NPEAKS*FREQ_W-1:0]    freqs_out,
    output logic [NPEAKS-1:0]           found_out,
    output logic [TIME_W-1:0]           counter_out,
    output logic                        frame_err
);

    localparam logic [FREQ_W-1:0] LAST_IDX = FREQ_W'(NFREQS - 1);
    localparam logic signed [AMPL_W-1:0] MIN_AMP = {1'b1, {(AMPL_W-1){1'b0}}};

    typedef enum logic [1:0] {FILL0, FILL1, RUN} state_t;

    state_t state_q, state_d;

    logic signed [AMPL_W-1:0] prev_q [NFREQS];
    logic signed [AMPL_W-1:0] curr_q [NFREQS];
    logic signed [AMPL_W-1:0] next_q [NFREQS];

    logic [FREQ_W-1:0]         idx_q;
    logic [NPEAKS*FREQ_W-1:0]  edges_q;

    logic signed [AMPL_W-1:0]  acc_amp_q [NPEAKS];
    logic [FREQ_W-1:0]         acc_freq_q [NPEAKS];
    logic [NPEAKS-1:0]         acc_found_q;
    logic signed [AMPL_W-1:0]  acc_amp_d [NPEAKS];
    logic [FREQ_W-1:0]         acc_freq_d [NPEAKS];
    logic [NPEAKS-1:0]         acc_found_d;

    logic                      fire;
    logic                      is_last_idx;
    logic                      bad;
    logic                      good_last;
    logic                      load;
    logic                      run;
    logic [FREQ_W-1:0]         idx_m1;
    logic [FREQ_W-1:0]         idx_p1;
    logic signed [AMPL_W-1:0]  centre;
    logic signed [AMPL_W-1:0]  left_n;
    logic signed [AMPL_W-1:0]  right_n;
    logic                      peak;
    logic [NPEAKS*FREQ_W-1:0]  edges_eff;
    logic [NPEAKS-1:0]         in_bin;

    assign run         = (state_q == RUN);
    assign is_last_idx = (idx_q == LAST_IDX);
    // Stall only the closing beat of a frame that would overwrite a held result.
    assign in_ready    = !(out_valid && !out_ready && run && in_last && is_last_idx);
    assign fire        = in_valid && in_ready;
    assign bad         = fire && (in_last != is_last_idx);
    assign good_last   = fire && in_last && is_last_idx;
    assign load        = good_last && run;

    // Neighbour lookup around the bin under evaluation, edges padded with MIN.
    always_comb begin
        idx_m1  = (idx_q == '0) ? '0 : idx_q - 1'b1;
        idx_p1  = is_last_idx ? idx_q : idx_q + 1'b1;
        centre  = curr_q[idx_q];
        left_n  = (idx_q == '0) ? MIN_AMP : curr_q[idx_m1];
        right_n = is_last_idx ? MIN_AMP : curr_q[idx_p1];
        peak    = (centre >= left_n) && (centre >= right_n) &&
                  (centre >= prev_q[idx_q]) && (centre >= in_data) &&
                  (centre > threshold);
    end

    // Bin membership: above previous edge and at or below own edge.
    always_comb begin
        logic above;
        logic [FREQ_W-1:0] edge_b;
        edges_eff = (idx_q == '0) ? bin_edges : edges_q;
        above     = 1'b1;
        in_bin    = '0;
        for (int b = 0; b < NPEAKS; b++) begin
            edge_b    = edges_eff[b*FREQ_W +: FREQ_W];
            in_bin[b] = above && (idx_q <= edge_b);
            above     = (idx_q > edge_b);
        end
    end

    // Per-bin best peak, restarting at the first sample of each frame.
    always_comb begin
        for (int b = 0; b < NPEAKS; b++) begin
            if (idx_q == '0) begin
                acc_amp_d[b]   = '0;
                acc_freq_d[b]  = '0;
                acc_found_d[b] = 1'b0;
            end else begin
                acc_amp_d[b]   = acc_amp_q[b];
                acc_freq_d[b]  = acc_freq_q[b];
                acc_found_d[b] = acc_found_q[b];
            end
            if (peak && in_bin[b] && (!acc_found_d[b] || centre > acc_amp_d[b])) begin
                acc_amp_d[b]   = centre;
                acc_freq_d[b]  = idx_q;
                acc_found_d[b] = 1'b1;
            end
        end
    end

    // Fill-state progression on each good frame.
    always_comb begin
        state_d = state_q;
        if (good_last) begin
            unique case (state_q)
                FILL0:   state_d = FILL1;
                FILL1:   state_d = RUN;
                default: state_d = RUN;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= FILL0;
        else       state_q <= state_d;
    end

    // Frame stores: fill next, rotate on a good closing beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NFREQS; i++) begin
                prev_q[i] <= '0;
                curr_q[i] <= '0;
                next_q[i] <= '0;
            end
        end else if (fire) begin
            next_q[idx_q] <= in_data;
            if (good_last) begin
                for (int i = 0; i < NFREQS; i++) begin
                    prev_q[i] <= curr_q[i];
                    curr_q[i] <= (i == NFREQS - 1) ? in_data : next_q[i];
                end
            end
        end
    end

    // Sample index, edge snapshot and framing-error pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q     <= '0;
            edges_q   <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= bad;
            if (fire) begin
                if (idx_q == '0) edges_q <= bin_edges;
                if (bad || good_last) idx_q <= '0;
                else                  idx_q <= idx_q + 1'b1;
            end
        end
    end

    // Running per-bin accumulators.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < NPEAKS; b++) begin
                acc_amp_q[b]  <= '0;
                acc_freq_q[b] <= '0;
            end
            acc_found_q <= '0;
        end else if (fire && run) begin
            for (int b = 0; b < NPEAKS; b++) begin
                acc_amp_q[b]  <= acc_amp_d[b];
                acc_freq_q[b] <= acc_freq_d[b];
            end
            acc_found_q <= acc_found_d;
        end
    end

    // Result register with valid/ready hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid      <= 1'b0;
            amplitudes_out <= '0;
            freqs_out      <= '0;
            found_out      <= '0;
            counter_out    <= '0;
        end else if (load) begin
            out_valid   <= 1'b1;
            counter_out <= counter_out + 1'b1;
            found_out   <= acc_found_d;
            for (int b = 0; b < NPEAKS; b++) begin
                amplitudes_out[b*FINAL_W +: FINAL_W] <= acc_amp_d[b][AMPL_W-1 -: FINAL_W];
                freqs_out[b*FREQ_W +: FREQ_W]        <= acc_freq_d[b];
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/spectral_peak_picker.md
SPECTRAL_PEAK_PICKER -- requirements
Module: spectral_peak_picker

Interface
REQ-001 Parameter NFREQS, default 256: FFT magnitudes per frame, at least 4.
REQ-002 Parameter NPEAKS, default 6: frequency bins, so peaks reported per frame, at least 1.
REQ-003 Parameter AMPL_W, default 32: signed input amplitude width.
REQ-004 Parameter FINAL_W, default 8: signed output amplitude width, at most AMPL_W.
REQ-005 Parameter FREQ_W, default $clog2(NFREQS): frequency index width.
REQ-006 Parameter TIME_W, default 16: frame counter width.
REQ-007 clk  in  1  clock; all state changes on posedge clk.
REQ-008 reset  in  1  reset, asynchronous, active-high.
REQ-009 in_valid  in  1  in_data/in_last valid.
REQ-010 in_ready  out  1  block accepts a sample this cycle.
REQ-011 in_data  in  AMPL_W  signed magnitude; accepted in frequency order 0..NFREQS-1.
REQ-012 in_last  in  1  marks frequency index NFREQS-1.
REQ-013 bin_edges  in  NPEAKS*FREQ_W  upper inclusive index per bin, slice b = edge[b]; strictly increasing, edge[NPEAKS-1]=NFREQS-1.
REQ-014 threshold  in  AMPL_W  signed minimum amplitude for a valid peak.
REQ-015 out_valid  out  1  result set valid; held until out_ready.
REQ-016 out_ready  in  1  consumer accepts result.
REQ-017 amplitudes_out  out  NPEAKS*FINAL_W  per-bin peak amplitude.
REQ-018 freqs_out  out  NPEAKS*FREQ_W  per-bin peak index.
REQ-019 found_out  out  NPEAKS  per-bin peak-present flag.
REQ-020 counter_out  out  TIME_W  sequence number of presented result.
REQ-021 frame_err  out  1  one-cycle pulse on framing error.

Function
REQ-022 Transfer on in_valid&&in_ready; out handshake on out_valid&&out_ready.
REQ-023 Three frame stores prev, curr, next; on accepted in_last: prev<=curr, curr<=next (next being filled).
REQ-024 States FILL0, FILL1, RUN: FILL0->FILL1 after first good frame, FILL1->RUN after second; no results in FILL states.
REQ-025 In RUN, accepting sample i of the new frame evaluates curr[i]: peak iff curr[i] >= curr[i-1], curr[i+1], prev[i], new sample i, and curr[i] > threshold.
REQ-026 Out-of-range neighbours (i-1<0, i+1>=NFREQS) equal the most negative AMPL_W value.
REQ-027 curr[i] lies in bin b where edge[b-1] < i <= edge[b] (edge[-1] = -1); bin_edges sampled at first sample of each evaluating frame.
REQ-028 Per bin, keep the largest qualifying peak; equal amplitudes keep the lower index (strict > replaces).
REQ-029 Bin without peak: found=0, amplitude=0, freq=0.
REQ-030 Result registered cycle after accepted in_last of evaluating frame: out_valid=1, amplitudes_out = top FINAL_W bits of AMPL_W value, counter_out incremented (wraps at 2^TIME_W).
REQ-031 in_ready=0 while out_valid=1 and out_ready=0 at the point a new result would be produced (on in_last beat only); otherwise in_ready=1.
REQ-032 out_valid and result bits stable until handshake; out_valid drops cycle after handshake unless new result loads same cycle.
REQ-033 in_last at index != NFREQS-1, or index NFREQS-1 without in_last: frame_err pulses, that frame discarded, stores and state unchanged, index restarts at 0.

Reset
REQ-034 Reset: stores cleared to 0, state FILL0, index 0, out_valid=0, amplitudes_out/freqs_out/found_out=0, counter_out=0, frame_err=0, in_ready=1.
REQ-035 Reset mid-frame or with out_valid pending discards all partial and pending data; no output after deassertion until two new good frames plus one.

Verification
REQ-036 NFREQS=8, NPEAKS=2, edges{3,7}, threshold=0; frames F0=0s, F1=[0,5,0,0,0,0,9,0], F2=0s -> after F2 last: found=11, freqs{1,6}, counter_out=1.
REQ-037 Same, F1 bin0 [4,4,0,0]: freq0=0 (tie keeps lower), amplitude top bits of 4.
REQ-038 threshold=10 with REQ-036 data -> found=00, freqs/amplitudes 0.
REQ-039 out_ready=0 over two further frames -> in_ready low on second in_last beat, first result held unchanged, no frame lost after out_ready=1.
REQ-040 in_last at index 5 -> frame_err one pulse, next good frame treated as if error frame never arrived.
REQ-041 reset asserted mid-frame in RUN -> all outputs 0 next edge, counter_out restarts from 1 on first post-reset result.
